// File: rtl/zvc_stream_compressor.sv
// Zero-value compressor: drops zero words of a line and packs survivors (with their
// mapping-table entries) into low lanes over a 3-stage stalling pipeline. Optional
// statistics counters are built when ZVC_STATS_EN is defined.
module zvc_stream_compressor #(
    parameter int WORD_WIDTH    = 8,
    parameter int LINE_SIZE     = 32,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 3,
    localparam int MT_W  = DIST_WIDTH * MAX_LIFM_RSIZ,
    localparam int CNT_W = $clog2(LINE_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_bypass,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_vec,
    input  logic [LINE_SIZE*MT_W-1:0]     mt_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
    output logic [LINE_SIZE*MT_W-1:0]     mt_comp,
    output logic [LINE_SIZE-1:0]          nz_mask,
    output logic [CNT_W-1:0]              comp_cnt
`ifdef ZVC_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [31:0]                   stat_lines,
    output logic [31:0]                   stat_zeros
`endif
);
    localparam int IDX_W = $clog2(LINE_SIZE);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // S1: capture line, nonzero map and the packing mask (all-ones on bypass)
    logic                            v1;
    logic [LINE_SIZE*WORD_WIDTH-1:0] lifm1;
    logic [LINE_SIZE*MT_W-1:0]       mt1;
    logic [LINE_SIZE-1:0]            nz1, mask1, nz_in;

    always_comb begin
        nz_in = '0;
        for (int i = 0; i < LINE_SIZE; i++)
            nz_in[i] = |lifm_vec[i*WORD_WIDTH +: WORD_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            lifm1 <= '0;
            mt1   <= '0;
            nz1   <= '0;
            mask1 <= '0;
        end else if (adv) begin
            v1    <= in_valid;
            lifm1 <= lifm_vec;
            mt1   <= mt_vec;
            nz1   <= nz_in;
            mask1 <= in_bypass ? {LINE_SIZE{1'b1}} : nz_in;
        end
    end

    // S2: exclusive prefix sum gives each surviving lane its destination
    logic                            v2;
    logic [LINE_SIZE*WORD_WIDTH-1:0] lifm2;
    logic [LINE_SIZE*MT_W-1:0]       mt2;
    logic [LINE_SIZE-1:0]            nz2, mask2;
    logic [LINE_SIZE-1:0][IDX_W-1:0] dest_nxt, dest2;
    logic [CNT_W-1:0]                total_nxt, total2;

    always_comb begin
        total_nxt = '0;
        dest_nxt  = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            dest_nxt[i] = total_nxt[IDX_W-1:0];
            total_nxt   = total_nxt + CNT_W'(mask1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2     <= 1'b0;
            lifm2  <= '0;
            mt2    <= '0;
            nz2    <= '0;
            mask2  <= '0;
            dest2  <= '0;
            total2 <= '0;
        end else if (adv) begin
            v2     <= v1;
            lifm2  <= lifm1;
            mt2    <= mt1;
            nz2    <= nz1;
            mask2  <= mask1;
            dest2  <= dest_nxt;
            total2 <= total_nxt;
        end
    end

    // S3: scatter survivors; untouched lanes stay zero
    logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_nxt;
    logic [LINE_SIZE*MT_W-1:0]       mt_nxt;

    always_comb begin
        lifm_nxt = '0;
        mt_nxt   = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (mask2[i]) begin
                lifm_nxt[int'(dest2[i])*WORD_WIDTH +: WORD_WIDTH] = lifm2[i*WORD_WIDTH +: WORD_WIDTH];
                mt_nxt[int'(dest2[i])*MT_W +: MT_W]               = mt2[i*MT_W +: MT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            lifm_comp <= '0;
            mt_comp   <= '0;
            nz_mask   <= '0;
            comp_cnt  <= '0;
        end else if (adv) begin
            out_valid <= v2;
            lifm_comp <= lifm_nxt;
            mt_comp   <= mt_nxt;
            nz_mask   <= nz2;
            comp_cnt  <= total2;
        end
    end

`ifdef ZVC_STATS_EN
    logic [CNT_W-1:0] nz_pop;
    logic [31:0]      zeros_inc;
    logic [32:0]      zeros_sum;

    always_comb begin
        nz_pop = '0;
        for (int i = 0; i < LINE_SIZE; i++)
            nz_pop = nz_pop + CNT_W'(nz_mask[i]);
        zeros_inc = 32'(LINE_SIZE) - 32'(nz_pop);
        zeros_sum = {1'b0, stat_zeros} + {1'b0, zeros_inc};
    end

    // Clear takes priority over a same-cycle handshake; both counters saturate
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_lines <= '0;
            stat_zeros <= '0;
        end else if (out_valid && out_ready) begin
            if (stat_lines != 32'hFFFF_FFFF)
                stat_lines <= stat_lines + 32'd1;
            stat_zeros <= zeros_sum[32] ? 32'hFFFF_FFFF : zeros_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_zvc_stream_compressor.sv
// Directed bench for zvc_stream_compressor (LINE_SIZE=4); the stats section is only
// exercised when ZVC_STATS_EN is defined.
module tb_zvc_stream_compressor;
    localparam int WW = 8;
    localparam int LS = 4;
    localparam int DW = 7;
    localparam int RS = 3;
    localparam int MW = DW * RS;
    localparam int CW = $clog2(LS + 1);

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, in_bypass, out_valid, out_ready;
    logic [LS*WW-1:0] lifm_vec, lifm_comp;
    logic [LS*MW-1:0] mt_vec, mt_comp;
    logic [LS-1:0]    nz_mask;
    logic [CW-1:0]    comp_cnt;
    logic             stat_clr;
    logic [31:0]      stat_lines, stat_zeros;

    int n_assert = 0;
    int n_fail   = 0;

    zvc_stream_compressor #(
        .WORD_WIDTH(WW), .LINE_SIZE(LS), .DIST_WIDTH(DW), .MAX_LIFM_RSIZ(RS)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_bypass(in_bypass), .lifm_vec(lifm_vec), .mt_vec(mt_vec),
        .out_valid(out_valid), .out_ready(out_ready), .lifm_comp(lifm_comp),
        .mt_comp(mt_comp), .nz_mask(nz_mask), .comp_cnt(comp_cnt)
`ifdef ZVC_STATS_EN
        , .stat_clr(stat_clr), .stat_lines(stat_lines), .stat_zeros(stat_zeros)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [MW-1:0] MA = 21'h10001;
    localparam logic [MW-1:0] MB = 21'h0A0B2;
    localparam logic [MW-1:0] MC = 21'h0C0C3;
    localparam logic [MW-1:0] MD = 21'h1D0D4;

    function automatic logic [LS*WW-1:0] lv(input logic [7:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [LS*MW-1:0] mv(input logic [MW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [MW-1:0] mte(input int k, input int j);
        return MW'(32'h1000 * (k + 1) + j + 1);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [LS*WW-1:0] el,
                           input logic [LS*MW-1:0] em, input logic [LS-1:0] emask,
                           input logic [CW-1:0] ecnt);
        chk({tag, "_valid"}, 128'(out_valid), 128'(ev));
        chk({tag, "_lifm"},  128'(lifm_comp), 128'(el));
        chk({tag, "_mt"},    128'(mt_comp),   128'(em));
        chk({tag, "_mask"},  128'(nz_mask),   128'(emask));
        chk({tag, "_cnt"},   128'(comp_cnt),  128'(ecnt));
    endtask

    logic [LS*WW-1:0] t4_in [6];
    logic [LS*MW-1:0] t4_mt [6];
    logic [LS*WW-1:0] t4_el [6];
    logic [LS*MW-1:0] t4_em [6];
    logic [LS-1:0]    t4_mask [6];
    logic [CW-1:0]    t4_cnt [6];
    int sent, recv;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
        lifm_vec = '0; mt_vec = '0; stat_clr = 1'b0;
        repeat (2) step;
        chk_out("reset", 1'b0, '0, '0, '0, '0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(1'b1));

        // 1: basic packing and 3-cycle latency
        in_valid = 1'b1;
        lifm_vec = lv(8'h00, 8'h11, 8'h00, 8'h22);
        mt_vec   = mv(MA, MB, MC, MD);
        step;
        in_valid = 1'b0;
        chk("t1_lat1", 128'(out_valid), 128'(1'b0));
        step;
        chk("t1_lat2", 128'(out_valid), 128'(1'b0));
        step;
        chk_out("t1", 1'b1, lv(8'h11, 8'h22, 8'h00, 8'h00), mv(MB, MD, '0, '0), 4'b1010, 3'd2);

        // 2: all-zero line followed by an all-nonzero line
        in_valid = 1'b1;
        lifm_vec = '0;
        mt_vec   = mv(MA, MB, MC, MD);
        step;
        lifm_vec = lv(8'h05, 8'h06, 8'h07, 8'h08);
        step;
        in_valid = 1'b0;
        step;
        chk_out("t2_zero", 1'b1, '0, '0, 4'b0000, 3'd0);
        step;
        chk_out("t2_full", 1'b1, lv(8'h05, 8'h06, 8'h07, 8'h08), mv(MA, MB, MC, MD), 4'b1111, 3'd4);
        step;
        chk("t2_drain", 128'(out_valid), 128'(1'b0));

        // 3: bypass keeps zeros in place but reports the true nonzero map
        in_valid  = 1'b1;
        in_bypass = 1'b1;
        lifm_vec  = lv(8'h00, 8'h09, 8'h00, 8'h03);
        mt_vec    = mv(MA, MB, MC, MD);
        step;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        step;
        step;
        chk_out("t3", 1'b1, lv(8'h00, 8'h09, 8'h00, 8'h03), mv(MA, MB, MC, MD), 4'b1010, 3'd4);
        step;

        // 4: six back-to-back lines with a downstream stall in cycles 4..7
        t4_in[0] = lv(8'h01, 8'h00, 8'h02, 8'h00);
        t4_el[0] = lv(8'h01, 8'h02, 8'h00, 8'h00);
        t4_em[0] = mv(mte(0, 0), mte(0, 2), '0, '0); t4_mask[0] = 4'b0101; t4_cnt[0] = 3'd2;
        t4_in[1] = lv(8'h00, 8'h00, 8'h00, 8'h03);
        t4_el[1] = lv(8'h03, 8'h00, 8'h00, 8'h00);
        t4_em[1] = mv(mte(1, 3), '0, '0, '0);        t4_mask[1] = 4'b1000; t4_cnt[1] = 3'd1;
        t4_in[2] = lv(8'h04, 8'h05, 8'h06, 8'h07);
        t4_el[2] = lv(8'h04, 8'h05, 8'h06, 8'h07);
        t4_em[2] = mv(mte(2, 0), mte(2, 1), mte(2, 2), mte(2, 3)); t4_mask[2] = 4'b1111; t4_cnt[2] = 3'd4;
        t4_in[3] = lv(8'h00, 8'h08, 8'h09, 8'h00);
        t4_el[3] = lv(8'h08, 8'h09, 8'h00, 8'h00);
        t4_em[3] = mv(mte(3, 1), mte(3, 2), '0, '0); t4_mask[3] = 4'b0110; t4_cnt[3] = 3'd2;
        t4_in[4] = lv(8'h0A, 8'h00, 8'h00, 8'h00);
        t4_el[4] = lv(8'h0A, 8'h00, 8'h00, 8'h00);
        t4_em[4] = mv(mte(4, 0), '0, '0, '0);        t4_mask[4] = 4'b0001; t4_cnt[4] = 3'd1;
        t4_in[5] = '0;
        t4_el[5] = '0;
        t4_em[5] = '0;                                t4_mask[5] = 4'b0000; t4_cnt[5] = 3'd0;
        for (int k = 0; k < 6; k++)
            t4_mt[k] = mv(mte(k, 0), mte(k, 1), mte(k, 2), mte(k, 3));

        sent = 0;
        recv = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                lifm_vec = t4_in[sent];
                mt_vec   = t4_mt[sent];
            end
            #1;
            if (c >= 4 && c <= 7) begin
                chk("t4_stall_valid", 128'(out_valid), 128'(1'b1));
                chk("t4_stall_in_ready", 128'(in_ready), 128'(1'b0));
            end
            if (out_valid && recv < 6) begin
                chk("t4_lifm", 128'(lifm_comp), 128'(t4_el[recv]));
                chk("t4_mt",   128'(mt_comp),   128'(t4_em[recv]));
                chk("t4_mask", 128'(nz_mask),   128'(t4_mask[recv]));
                chk("t4_cnt",  128'(comp_cnt),  128'(t4_cnt[recv]));
                if (out_ready)
                    recv++;
            end
            if (in_valid && in_ready)
                sent++;
            step;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_recv_count", 128'(recv), 128'(6));
        chk("t4_sent_count", 128'(sent), 128'(6));
        step;
        chk("t4_drain", 128'(out_valid), 128'(1'b0));

        // 5: reset with two lines in flight
        mt_vec   = mv(MA, MB, MC, MD);
        in_valid = 1'b1;
        lifm_vec = lv(8'h01, 8'h01, 8'h01, 8'h01);
        step;
        lifm_vec = lv(8'h02, 8'h00, 8'h00, 8'h02);
        step;
        in_valid = 1'b0;
        reset    = 1'b1;
        step;
        reset = 1'b0;
        chk("t5_after_reset", 128'(out_valid), 128'(1'b0));
        step;
        chk("t5_flush1", 128'(out_valid), 128'(1'b0));
        step;
        chk("t5_flush2", 128'(out_valid), 128'(1'b0));
        in_valid = 1'b1;
        lifm_vec = lv(8'h00, 8'h00, 8'h07, 8'h00);
        step;
        in_valid = 1'b0;
        step;
        chk("t5_lat2", 128'(out_valid), 128'(1'b0));
        step;
        chk_out("t5", 1'b1, lv(8'h07, 8'h00, 8'h00, 8'h00), mv(MC, '0, '0, '0), 4'b0100, 3'd1);

`ifdef ZVC_STATS_EN
        // 6: statistics; clear coincides with the t5 line's handshake
        stat_clr = 1'b1;
        step;
        stat_clr = 1'b0;
        chk("t6_clr_lines", 128'(stat_lines), 128'(0));
        chk("t6_clr_zeros", 128'(stat_zeros), 128'(0));
        in_valid = 1'b1;
        lifm_vec = lv(8'h01, 8'h00, 8'h02, 8'h03);
        step;
        lifm_vec = '0;
        step;
        lifm_vec = lv(8'h01, 8'h02, 8'h03, 8'h04);
        step;
        in_valid = 1'b0;
        repeat (4) step;
        chk("t6_lines", 128'(stat_lines), 128'(3));
        chk("t6_zeros", 128'(stat_zeros), 128'(5));
        stat_clr = 1'b1;
        step;
        stat_clr = 1'b0;
        chk("t6_clr2_lines", 128'(stat_lines), 128'(0));
        chk("t6_clr2_zeros", 128'(stat_zeros), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
